// File: rtl/led_breath_ctrl_if.sv
// Control/status bundle for led_breath_ctrl: start/stop handshake, ramp settings,
// brightness level, PWM drive and status. Signal prefixes are from the controller's view.
interface led_breath_ctrl_if;
    logic       i_start;
    logic       i_stop;
    logic [7:0] i_step;
    logic [7:0] i_hold;
    logic [7:0] o_level;
    logic       o_pwm_out;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_breaths;

    modport master (
        output i_start, i_stop, i_step, i_hold,
        input  o_level, o_pwm_out, o_busy, o_done, o_breaths
    );

    modport slave (
        input  i_start, i_stop, i_step, i_hold,
        output o_level, o_pwm_out, o_busy, o_done, o_breaths
    );
endinterface

// File: rtl/led_breath_ctrl.sv
// LED breathing sequencer: prescaled ramp up / hold / ramp down / hold, with registered PWM.
// Optional macro LED_BREATH_GAMMA_EN squares the level before the PWM compare.
module led_breath_ctrl #(
    parameter int PRESC = 50000,
    parameter int PWM_W = 8
) (
    input logic              clk,
    input logic              rst,
    led_breath_ctrl_if.slave bus
);

    localparam int              PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
    localparam logic [PWM_W-1:0] LVL_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_HOLD_H,
        S_DOWN,
        S_HOLD_L
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_presc;
    logic [PWM_W-1:0]  r_level;
    logic [PWM_W-1:0]  r_step;
    logic [PWM_W-1:0]  r_hold;
    logic [PWM_W-1:0]  r_holdCnt;
    logic [PWM_W-1:0]  r_breaths;
    logic [PWM_W-1:0]  r_pwmCnt;
    logic              r_stopPend;
    logic              r_busy;
    logic              r_done;
    logic              r_pwmOut;

    logic              w_tick;
    logic              w_accept;
    logic              w_holdDone;
    logic              w_breathEnd;
    logic [PWM_W:0]    w_sum;
    logic [PWM_W-1:0]  w_levelNext;
    logic [PWM_W-1:0]  w_holdCntNext;
    logic [PWM_W-1:0]  w_cmp;

    assign w_tick     = (r_state != S_IDLE) && (r_presc == PRESC_LAST);
    assign w_accept   = (r_state == S_IDLE) && bus.i_start && !bus.i_stop;
    assign w_holdDone = (r_holdCnt == r_hold);
    assign w_sum      = {1'b0, r_level} + {1'b0, r_step};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_UP;
                end
            end
            S_UP: begin
                if (w_tick && (w_sum >= {1'b0, LVL_MAX})) begin
                    w_next = S_HOLD_H;
                end
            end
            S_HOLD_H: begin
                if (w_tick && w_holdDone) begin
                    w_next = S_DOWN;
                end
            end
            S_DOWN: begin
                if (w_tick && (r_level <= r_step)) begin
                    w_next = S_HOLD_L;
                end
            end
            S_HOLD_L: begin
                if (w_tick && w_holdDone) begin
                    w_next = r_stopPend ? S_IDLE : S_UP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath next values; the hold counter compares before incrementing so hold=0 exits at once.
    always_comb begin
        w_levelNext   = r_level;
        w_holdCntNext = r_holdCnt;
        w_breathEnd   = 1'b0;
        case (r_state)
            S_UP: begin
                if (w_tick) begin
                    if (w_sum >= {1'b0, LVL_MAX}) begin
                        w_levelNext   = LVL_MAX;
                        w_holdCntNext = '0;
                    end else begin
                        w_levelNext = w_sum[PWM_W-1:0];
                    end
                end
            end
            S_HOLD_H: begin
                if (w_tick && !w_holdDone) begin
                    w_holdCntNext = r_holdCnt + 1'b1;
                end
            end
            S_DOWN: begin
                if (w_tick) begin
                    if (r_level <= r_step) begin
                        w_levelNext   = '0;
                        w_holdCntNext = '0;
                    end else begin
                        w_levelNext = r_level - r_step;
                    end
                end
            end
            S_HOLD_L: begin
                if (w_tick) begin
                    if (w_holdDone) begin
                        w_breathEnd = 1'b1;
                    end else begin
                        w_holdCntNext = r_holdCnt + 1'b1;
                    end
                end
            end
            default: begin
                w_levelNext = r_level;
            end
        endcase
    end

`ifdef LED_BREATH_GAMMA_EN
    logic [15:0] w_sq;
    assign w_sq  = 16'(r_level) * 16'(r_level);
    assign w_cmp = PWM_W'(w_sq >> 8);
`else
    assign w_cmp = r_level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_level    <= '0;
            r_step     <= '0;
            r_hold     <= '0;
            r_holdCnt  <= '0;
            r_breaths  <= '0;
            r_stopPend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pwmCnt   <= '0;
            r_pwmOut   <= 1'b0;
        end else begin
            r_presc   <= ((r_state == S_IDLE) || w_tick) ? '0 : r_presc + 1'b1;
            r_level   <= w_levelNext;
            r_holdCnt <= w_holdCntNext;
            if (w_accept) begin
                r_step <= (bus.i_step == '0) ? PWM_W'(1) : bus.i_step;
                r_hold <= bus.i_hold;
            end
            if (w_breathEnd) begin
                r_breaths <= r_breaths + 1'b1;
            end
            // A stop request is remembered until the breath that follows it ends at level 0.
            if (r_state == S_IDLE) begin
                r_stopPend <= 1'b0;
            end else if (w_breathEnd && r_stopPend) begin
                r_stopPend <= 1'b0;
            end else if (bus.i_stop) begin
                r_stopPend <= 1'b1;
            end
            r_done   <= w_breathEnd && r_stopPend;
            r_busy   <= (w_next != S_IDLE);
            r_pwmCnt <= r_pwmCnt + 1'b1;
            r_pwmOut <= (r_pwmCnt < w_cmp);
        end
    end

    assign bus.o_level   = r_level;
    assign bus.o_pwm_out = r_pwmOut;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_breaths = r_breaths;

endmodule

// File: tb/tb_led_breath_ctrl.sv
// Scoreboard bench for led_breath_ctrl: a tick-level breath model queues expected
// level/breaths/done events with their cycle; a monitor pops them as the DUT shows them.
module tb_led_breath_ctrl;

    localparam int PRESC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    led_breath_ctrl_if bus ();

    led_breath_ctrl #(
        .PRESC(PRESC),
        .PWM_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef enum int {EV_LEVEL, EV_BREATHS, EV_DONE} evKind_t;

    typedef struct {
        evKind_t kind;
        int      value;
        int      cyc;
        int      busy;
    } expEv_t;

    expEv_t expQ[$];
    int     breathLvl[$];
    int     checks = 0;
    int     passes = 0;
    int     cyc = 0;
    logic   rstAtEdge = 1'b1;
    int     expBreaths = 0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rstAtEdge <= rst;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int cmpOf(input int l);
`ifdef LED_BREATH_GAMMA_EN
        return (l * l) / 256;
`else
        return l;
`endif
    endfunction

    // Levels seen after each tick of one whole breath: ramp up, dwell, ramp down, dwell.
    function automatic void buildBreath(input int s, input int h);
        int lvl;
        int st;
        st = (s == 0) ? 1 : s;
        breathLvl.delete();
        lvl = 0;
        while (lvl < 255) begin
            lvl = (lvl + st >= 255) ? 255 : lvl + st;
            breathLvl.push_back(lvl);
        end
        for (int i = 0; i <= h; i++) breathLvl.push_back(255);
        while (lvl > 0) begin
            lvl = (lvl <= st) ? 0 : lvl - st;
            breathLvl.push_back(lvl);
        end
        for (int i = 0; i <= h; i++) breathLvl.push_back(0);
    endfunction

    function automatic void pushEv(input evKind_t k, input int v, input int c, input int b);
        expEv_t e;
        e.kind  = k;
        e.value = v;
        e.cyc   = c;
        e.busy  = b;
        expQ.push_back(e);
    endfunction

    task automatic popAndCheck(input evKind_t k, input int v);
        expEv_t e;
        if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected %s event: got value %0d at cycle %0d, expected none",
                     k.name(), v, cyc);
        end else begin
            e = expQ.pop_front();
            checkOutput("event kind", int'(k), int'(e.kind));
            checkOutput({k.name(), " value"}, v, e.value);
            checkOutput({k.name(), " cycle"}, cyc, e.cyc);
            checkOutput({k.name(), " busy"}, int'(bus.o_busy), e.busy);
        end
    endtask

    // Monitor: PWM follows the level one clk late; every visible change must match the queue head.
    initial begin
        int prevLevel;
        int prevBreaths;
        int pwmCnt;
        prevLevel   = 0;
        prevBreaths = 0;
        pwmCnt      = 0;
        forever begin
            @(negedge clk);
            if (rstAtEdge) begin
                prevLevel   = 0;
                prevBreaths = 0;
                pwmCnt      = 0;
                expQ.delete();
            end else begin
                checkOutput("pwm_out", int'(bus.o_pwm_out), (pwmCnt < cmpOf(prevLevel)) ? 1 : 0);
                pwmCnt = (pwmCnt + 1) % 256;
                if (int'(bus.o_level) != prevLevel) popAndCheck(EV_LEVEL, int'(bus.o_level));
                if (int'(bus.o_breaths) != prevBreaths) popAndCheck(EV_BREATHS, int'(bus.o_breaths));
                if (bus.o_done) popAndCheck(EV_DONE, 1);
                prevLevel   = int'(bus.o_level);
                prevBreaths = int'(bus.o_breaths);
            end
        end
    end

    task automatic waitDrain(input int maxCycles);
        int k;
        k = 0;
        while (expQ.size() != 0 && k < maxCycles) begin
            @(negedge clk);
            k++;
        end
        if (expQ.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain timeout: got %0d events pending, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Runs n breaths with a stop landing inside the last one (stopOff<0 picks it at random);
    // stray start pulses with junk settings are sprinkled in while busy.
    task automatic applyStimulus(input int s, input int h, input int n, input int stopOff);
        int e0;
        int t;
        int lo;
        int hi;
        int stopEdge;
        int prev;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b0;
        bus.i_step  = 8'(s);
        bus.i_hold  = 8'(h);
        e0 = cyc + 1;
        buildBreath(s, h);
        t = breathLvl.size();
        for (int b = 0; b < n; b++) begin
            for (int ti = 0; ti < t; ti++) begin
                prev = (ti == 0) ? 0 : breathLvl[ti - 1];
                if (breathLvl[ti] != prev)
                    pushEv(EV_LEVEL, breathLvl[ti], e0 + PRESC * (b * t + ti + 1), 1);
                if (ti == t - 1) begin
                    expBreaths = (expBreaths + 1) % 256;
                    pushEv(EV_BREATHS, expBreaths, e0 + PRESC * (b * t + ti + 1), (b == n - 1) ? 0 : 1);
                    if (b == n - 1) pushEv(EV_DONE, 1, e0 + PRESC * (b * t + ti + 1), 0);
                end
            end
        end
        lo = e0 + PRESC * (n - 1) * t;
        hi = e0 + PRESC * n * t;
        stopEdge = (stopOff >= 0) ? e0 + stopOff : int'($urandom_range(hi - 1, lo + 1));
        @(negedge clk);
        bus.i_start = 1'b0;
        while (cyc < hi) begin
            bus.i_stop = (cyc == stopEdge - 1);
            if ($urandom_range(0, 15) == 0) begin
                bus.i_start = 1'b1;
                bus.i_step  = 8'($urandom);
                bus.i_hold  = 8'($urandom);
            end else begin
                bus.i_start = 1'b0;
            end
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        waitDrain(50);
        checkOutput("busy after stop", int'(bus.o_busy), 0);
    endtask

    initial begin
        int e0;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_step  = 8'd0;
        bus.i_hold  = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset level", int'(bus.o_level), 0);
        checkOutput("reset busy", int'(bus.o_busy), 0);
        checkOutput("reset pwm_out", int'(bus.o_pwm_out), 0);
        checkOutput("reset breaths", int'(bus.o_breaths), 0);
        checkOutput("reset done", int'(bus.o_done), 0);
        rst = 1'b0;

        // Reset in the middle of the first ramp, right after level reaches 40.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_step  = 8'd40;
        bus.i_hold  = 8'd0;
        e0 = cyc + 1;
        pushEv(EV_LEVEL, 40, e0 + PRESC, 1);
        @(negedge clk);
        bus.i_start = 1'b0;
        waitDrain(20);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-run reset level", int'(bus.o_level), 0);
        checkOutput("mid-run reset busy", int'(bus.o_busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expBreaths = 0;
        @(negedge clk);
        checkOutput("post-reset level", int'(bus.o_level), 0);
        checkOutput("post-reset busy", int'(bus.o_busy), 0);
        checkOutput("post-reset pwm_out", int'(bus.o_pwm_out), 0);
        checkOutput("post-reset breaths", int'(bus.o_breaths), 0);

        // Start and stop together while idle: nothing may happen.
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        bus.i_step  = 8'd10;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("start+stop busy", int'(bus.o_busy), 0);
        checkOutput("start+stop level", int'(bus.o_level), 0);

        applyStimulus(64, 1, 2, -1);
        applyStimulus(64, 1, 1, 2 * PRESC + 1);
        applyStimulus(0, 0, 1, -1);
        applyStimulus(255, 0, 2, -1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                          int'($urandom_range(1, 2)), -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion by %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/led_breath_ctrl.md
Name: led_breath_ctrl

Overview:
Sequencer for the LED brightness datapath. Ramps an 8-bit brightness level up and down with programmable step and hold times. Paced by an internal prescaled tick, with a start/stop handshake. Drives a registered PWM output to the LED pin and reports status (busy, done, breath count) to the top level.

Parameters:
PRESC, 50000, clk cycles per brightness tick (min 1; bench uses 2)
PWM_W, 8, PWM counter / level width (fixed 8 in this revision)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse: begin breathing (honoured only in IDLE)
stop  in  1  1-cycle pulse: request stop at end of current breath
step  in  8  level increment/decrement per tick; latched on accepted start
hold  in  8  ticks to dwell at full and zero brightness; latched on accepted start
level  out  8  current linear brightness
pwm_out  out  1  registered PWM drive to LED
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse when returning to IDLE after stop
breaths  out  8  completed breath count, wraps 255->0

Behaviour:
- Reset: synchronous, active-high, one clk; wins over all other inputs, also mid-operation.
- Reset values: state=IDLE, level=0, pwm_out=0, busy=0, done=0, breaths=0; prescaler=0, PWM counter=0, hold counter=0, stop_pend=0.
- Prescaler:
  - counts 0..PRESC-1 only while busy; held at 0 in IDLE.
  - tick=1 for one clk when count==PRESC-1.
  - all state/level updates below occur only on tick cycles, except start/stop capture.
- States: IDLE, UP, HOLD_H, DOWN, HOLD_L.
- IDLE:
  - start=1 and stop=0: latch step_r=(step==0)?1:step and hold_r=hold; go UP next clk; level stays 0.
  - start and stop together in IDLE: stop wins; remain IDLE, no done pulse.
- UP, on tick: sum=level+step_r computed 9-bit.
  - sum>=255: level=255, enter HOLD_H, hold counter=0.
  - otherwise: level=sum.
- HOLD_H, on tick: hold counter++.
  - exit to DOWN when counter==hold_r.
  - hold_r=0: exits on the first tick.
- DOWN, on tick:
  - level<=step_r: level=0, enter HOLD_L, hold counter=0.
  - otherwise: level=level-step_r.
  - no underflow possible.
- HOLD_L, on the tick where counter==hold_r: breaths++ (wraps), then:
  - stop_pend=1: go IDLE, done=1 for that clk, stop_pend cleared.
  - otherwise: go UP.
- stop:
  - any cycle while busy, stop=1 sets stop_pend (sticky).
  - the breath always finishes at level 0 before IDLE.
- start while busy: ignored; step/hold changes while busy have no effect until the next accepted start.
- busy: registered, equals (state!=IDLE).
- PWM:
  - free-running 8-bit counter pwm_cnt, increments every clk (wraps), also in IDLE.
  - pwm_out <= (pwm_cnt < cmp), where cmp=level; 1-clk latency from level.
  - level=0: pwm_out constantly 0. level=255: 255 of 256 cycles high.

Optional Feature:
LED_BREATH_GAMMA_EN:
- Defined: cmp=(level*level)>>8, 16-bit product, upper byte used; level=255 gives cmp=254; level output stays linear.
- Undefined: cmp=level; no multiplier is synthesised.

Test Plan:
- Reset: rst held 1 for 3 clk mid-UP with level=40 -> next clk level=0, busy=0, pwm_out=0, breaths=0, state IDLE.
- Basic breath (PRESC=2, step=64, hold=1): start pulse -> level sequence 64,128,192,255 on successive ticks; 2 ticks at 255; then 191,127,63,0; 2 ticks at 0; breaths=1; back to UP.
- Stop mid-ramp-up: stop at level=128 -> continues up to 255 then down to 0; done pulses exactly once; busy drops the same clk; breaths increments by 1.
- step=0, hold=0: start -> level increments by 1 per tick; 255 reached after 255 ticks; immediate DOWN on the next tick.
- Simultaneous start+stop in IDLE -> stays IDLE, busy=0, no done. A start pulse while busy -> no change to latched step/hold.
- PWM duty with level forced to 64 (linear build) -> pwm_out high 64 of every 256 clk. Gamma build at level 128 -> high 64 of 256.
